// File: rtl/mux_scan_seq_pkg.sv
// Shared definitions for the mux81 scan sequencer: channel geometry and FSM states.
package mux_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_seq.sv
// Scans mux81 channels 0..NCH-1, dwelling on enabled channels before sampling,
// and hands the captured word downstream over a valid/ready handshake.
module mux_scan_seq #(
    parameter int NCH   = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NCH-1:0]  chan_mask,
    output logic [SELW-1:0] sel,
    input  logic            mux_out,
    output logic            busy,
    output logic [NCH-1:0]  data,
    output logic            data_valid,
    input  logic            data_ready
);
    import mux_pkg::*;

    localparam logic [3:0]      CNT_INIT = 4'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

    state_t          state;
    logic [NCH-1:0]  mask;
    logic [SELW-1:0] ch;
    logic [3:0]      cnt;
    logic            accept;

    // A HOLD handshake cycle accepts a new start just like IDLE does.
    assign accept = start && ((state == IDLE) || (state == HOLD && data_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask       <= '0;
            ch         <= '0;
            cnt        <= '0;
            sel        <= '0;
            busy       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
        end else if (accept) begin
            sel  <= '0;
            data <= '0;
            if (chan_mask != '0) begin
                mask       <= chan_mask;
                ch         <= '0;
                cnt        <= CNT_INIT;
                busy       <= 1'b1;
                data_valid <= 1'b0;
                state      <= SCAN;
            end else begin
                data_valid <= 1'b1;
                state      <= HOLD;
            end
        end else begin
            case (state)
                IDLE: begin
                    sel <= '0;
                end
                SCAN: begin
                    if (mask[ch] && cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Masked channels keep the zero written at scan start.
                        if (mask[ch]) data[ch] <= mux_out;
                        if (ch == CH_LAST) begin
                            sel        <= '0;
                            busy       <= 1'b0;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            ch  <= ch + 1'b1;
                            sel <= ch + 1'b1;
                            cnt <= CNT_INIT;
                        end
                    end
                end
                HOLD: begin
                    sel <= '0;
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Upstream sequencer for the 8:1 bit multiplexer (mux81). It drives the mux select lines through channels 0..7, waits a programmable settle time on each enabled channel, and samples the mux output. The eight captured bits are presented as one parallel word to the next stage over a valid/ready handshake. One scan runs per start request.

Parameters:
NCH, 8, number of mux channels; fixed at 8 for mux81, and the sel width is log2(NCH).
SELW, 3, select width; must equal log2(NCH).
DWELL, 2, cycles sel is held on an enabled channel before sampling; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  scan request; sampled only in IDLE, or in HOLD on the handshake cycle
chan_mask  input  NCH  channel enable, latched at scan start; bit i=1 means channel i is sampled
sel  output  SELW  registered select to mux81 sel
mux_out  input  1  mux81 out, sampled synchronously
busy  output  1  high from the cycle after start is accepted until data_valid rises
data  output  NCH  captured word; data[i] = sample of channel i, 0 for masked channels
data_valid  output  1  word available; held until data_ready
data_ready  input  1  downstream accept

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low rst_n.
- Reset values: sel=0, busy=0, data=0, data_valid=0; FSM=IDLE; channel index=0; dwell counter=0; mask register=0.
- Any rst_n assertion aborts the scan in progress immediately. No partial word is ever presented.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - sel=0.
  - start=1 with chan_mask!=0: latch the mask, set ch=0, go to SCAN, drive sel=0, clear the data register.
  - start=1 with chan_mask==0: go directly to HOLD with data=0, so data_valid rises on the next edge.
- SCAN, current channel enabled (mask[ch]=1):
  - sel=ch for exactly DWELL cycles.
  - On the edge ending the DWELL-th cycle, capture mux_out into data[ch].
- SCAN, current channel masked:
  - sel=ch for 1 cycle, no sample, data[ch]=0.
- SCAN, channel advance:
  - Then ch increments.
  - When ch=NCH-1 completes, go to HOLD and assert data_valid. busy falls on the same edge.
  - ch does not wrap inside a scan.
- Latency: data_valid rises D*popcount(mask) + (NCH - popcount(mask)) cycles after the start-accept edge, where D=DWELL. All-ones mask with D=2 gives 16 cycles.
- HOLD:
  - data and data_valid stay stable while data_ready=0. sel=0.
  - data_valid=1 and data_ready=1 completes the transfer. data_valid falls on that edge and the FSM goes to IDLE.
  - If start=1 in that same cycle, go straight to SCAN with the current chan_mask (back-to-back scan, no idle bubble).
- start while busy or in HOLD without data_ready: ignored, not queued.
- chan_mask changes during a scan: no effect; the latched copy is used.
- data_ready while not data_valid: ignored.
- The dwell counter is a 4-bit down-counter loaded with DWELL-1 on entry to each enabled channel.

Decomposition:
- Shared package mux_pkg: localparams NCH=8, SELW=3; state enum {IDLE, SCAN, HOLD} (2-bit encoding).
- No sub-module. FSM, channel counter, dwell counter and capture register stay in one module.
- The testbench instantiates mux81 below this block: sel to sel, out to mux_out, in driven from the bench.

Test Plan:
- Reset mid-scan: assert rst_n low during SCAN ch=3 -> sel=0, busy=0, data_valid=0, data=0 asynchronously; no data_valid afterwards without a new start.
- Full scan: mux in=8'hA5, mask=8'hFF, DWELL=2, pulse start -> sel steps 0..7 holding 2 cycles each, data_valid at +16 cycles, data=8'hA5.
- Masked scan: in=8'hFF, mask=8'h0F -> data=8'h0F; data_valid at +12 cycles; sel dwells 1 cycle on channels 4..7.
- Empty mask: mask=8'h00, start -> data_valid the next cycle, data=8'h00, busy never rises.
- Backpressure: hold data_ready=0 for 5 cycles after valid and change in=8'h00 -> data stays 8'hA5. Start pulses during SCAN and HOLD are ignored.
- Back-to-back: data_ready=1 and start=1 in the same HOLD cycle with in=8'h3C -> data_valid drops, busy rises the next cycle, and the second word is 8'h3C after a further 16 cycles.
